// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch plus IF/ID latch; a word returned during a stall is held in HOLD.
// Optional FETCH_STAT_EN adds the stall_cnt / flush_cnt statistics outputs.
module fetch_stage #(
    parameter logic [31:0] PC_INIT  = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        pc_en,
    input  logic        flushed1,
    input  logic        id_en1,
    input  logic [1:0]  pc_src,
    input  logic [31:0] branch_target,
    input  logic [31:0] jump_target,
    input  logic [31:0] jr_target,
    input  logic        ihit,
    input  logic [31:0] iload,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_npc,
    output logic        if_id_valid,
    output logic        halted
`ifdef FETCH_STAT_EN
   ,output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);
    typedef enum logic [1:0] {FETCH, HOLD, HALT} state_t;
    state_t      state, state_nx;
    logic [31:0] pc, pc_nx, wbuf, wbuf_nx, word, target, pc_plus4;
    logic        avail, adv, redirect;
    assign avail    = (state == FETCH && ihit) || state == HOLD;
    assign word     = state == HOLD ? wbuf : iload;
    assign adv      = avail && pc_en && id_en1 && !flushed1;
    assign redirect = pc_en && pc_src != 2'd0 && flushed1;
    assign target   = pc_src == 2'd1 ? branch_target : pc_src == 2'd2 ? jump_target : jr_target;
    assign pc_plus4 = pc + 32'd4;
    assign imemREN  = nRST && state == FETCH;
    assign imemaddr = pc;
    assign halted   = state == HALT;
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= FETCH;
            pc    <= PC_INIT;
            wbuf  <= 32'd0;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
            wbuf  <= wbuf_nx;
        end
    end
    // Redirect beats everything and is the only way out of HALT.
    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        wbuf_nx  = wbuf;
        if (redirect) begin
            state_nx = FETCH;
            pc_nx    = target;
        end else if (adv) begin
            state_nx = word[31:26] == 6'h3f ? HALT : FETCH;
            pc_nx    = pc_src == 2'd0 ? pc_plus4 : target;
        end else if (flushed1) begin
            state_nx = state == HALT ? HALT : FETCH;
            pc_nx    = pc_en && avail ? pc_plus4 : pc;
        end else if (state == FETCH && ihit) begin
            state_nx = HOLD;
            wbuf_nx  = iload;
        end
    end
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            if_id_instr <= NOP_WORD;
            if_id_npc   <= 32'd0;
            if_id_valid <= 1'b0;
        end else if (flushed1) begin
            if_id_instr <= NOP_WORD;
            if_id_npc   <= 32'd0;
            if_id_valid <= 1'b0;
        end else if (id_en1) begin
            if_id_valid <= adv;
            if (adv) begin
                if_id_instr <= word;
                if_id_npc   <= pc_plus4;
            end
        end
    end
`ifdef FETCH_STAT_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt <= 32'd0;
            flush_cnt <= 32'd0;
        end else begin
            if (state != HALT && !adv && !flushed1) stall_cnt <= stall_cnt + 32'd1;
            if (flushed1) flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif
endmodule
